// File: rtl/mskaes_ctrl_pkg.sv
// Shared types and constants for the masked AES-128/256 control FSM.
package mskaes_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  localparam logic [1:0] KH_MODE_NONE = 2'b00;
  localparam logic [1:0] KH_MODE_ROT  = 2'b01;
  localparam logic [1:0] KH_MODE_SUB  = 2'b10;

  localparam int unsigned RND_W     = 4;
  localparam logic [3:0]  NR_128    = 4'd10;
  localparam logic [3:0]  NR_256    = 4'd14;
  localparam int unsigned FINAL_CYC = 4;

  // Key-schedule S-box mode for key k = rnd+1.
  // AES-256: k=1 needs no S-box, even k uses RotWord+SubWord+Rcon, odd k>=3 uses SubWord only.
  function automatic logic [1:0] kh_mode_for(input logic k256, input logic [RND_W-1:0] rnd);
    if (!k256)         return KH_MODE_ROT;
    else if (rnd == '0) return KH_MODE_NONE;
    else if (rnd[0])    return KH_MODE_ROT;
    else                return KH_MODE_SUB;
  endfunction

endpackage

// File: rtl/mskaes_32bits_multikey_fsm_if.sv
// Handshake and control bundle between the AES control FSM and its environment.
interface mskaes_32bits_multikey_fsm_if;
  logic       valid_in;
  logic       key256;
  logic       in_ready;
  logic       busy;
  logic       cipher_valid;
  logic       out_ready;
  logic       rnd_valid;
  logic       in_ready_rnd;
  logic       feed_input;
  logic       state_enable;
  logic       state_init;
  logic       state_en_MC;
  logic       kh_init;
  logic       kh_enable;
  logic [1:0] kh_mode;
  logic       rcon_rst;
  logic       rcon_update;
  logic       sbox_valid_in;
  logic       feed_sb_key;
  logic       sb_en;
  logic       enable_key_add;

  modport master (
    input  valid_in, key256, out_ready, rnd_valid,
    output in_ready, busy, cipher_valid, in_ready_rnd, feed_input,
           state_enable, state_init, state_en_MC, kh_init, kh_enable,
           kh_mode, rcon_rst, rcon_update, sbox_valid_in, feed_sb_key,
           sb_en, enable_key_add
  );

  modport slave (
    output valid_in, key256, out_ready, rnd_valid,
    input  in_ready, busy, cipher_valid, in_ready_rnd, feed_input,
           state_enable, state_init, state_en_MC, kh_init, kh_enable,
           kh_mode, rcon_rst, rcon_update, sbox_valid_in, feed_sb_key,
           sb_en, enable_key_add
  );
endinterface

// File: rtl/mskaes_sched_cnt.sv
// Round/step schedule counters with stall freeze and step-wrap detection.
module mskaes_sched_cnt
  import mskaes_ctrl_pkg::*;
#(
  parameter int unsigned SB_LAT = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             stall_i,
  output logic [RND_W-1:0] rnd_o,
  output logic [CNT_W-1:0] step_o,
  output logic             step_wrap_o
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(4 + SB_LAT);

  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [CNT_W-1:0] step_q, step_d;

  assign step_wrap_o = (step_q == STEP_LAST);
  assign rnd_o       = rnd_q;
  assign step_o      = step_q;

  // Next-count: clear, hold on stall, or advance with round carry at the last step.
  always_comb begin
    rnd_d  = rnd_q;
    step_d = step_q;
    if (clr_i) begin
      rnd_d  = '0;
      step_d = '0;
    end else if (en_i && !stall_i) begin
      if (step_wrap_o) begin
        step_d = '0;
        rnd_d  = rnd_q + 1'b1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q  <= '0;
      step_q <= '0;
    end else begin
      rnd_q  <= rnd_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/mskaes_32bits_multikey_fsm.sv
// Control FSM for the 32-bit masked AES-128/256 core with randomness stall.
module mskaes_32bits_multikey_fsm
  import mskaes_ctrl_pkg::*;
#(
  parameter int unsigned SB_LAT = 4,
  parameter int unsigned CNT_W  = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  mskaes_32bits_multikey_fsm_if.master bus
);

  state_e           state_q;
  logic             key256_q;
  logic [RND_W-1:0] rnd;
  logic [CNT_W-1:0] step;
  logic             step_wrap;

  logic             in_round, in_final;
  logic             col_step, key_step, drain_step;
  logic             last_round;
  logic [RND_W-1:0] last_rnd;
  logic [1:0]       kh_mode;
  logic             sbv_raw, rnd_req, stall;

  assign in_round   = (state_q == ST_ROUND);
  assign in_final   = (state_q == ST_FINAL);
  assign col_step   = in_round && (step <  CNT_W'(4));
  assign key_step   = in_round && (step == CNT_W'(4));
  assign drain_step = in_round && (step >  CNT_W'(4));
  assign last_rnd   = key256_q ? (NR_256 - 4'd1) : (NR_128 - 4'd1);
  assign last_round = (rnd == last_rnd);
  assign kh_mode    = kh_mode_for(key256_q, rnd);
  assign sbv_raw    = col_step || (key_step && (kh_mode != KH_MODE_NONE));
  assign rnd_req    = sbv_raw || drain_step;
  assign stall      = rnd_req && !bus.rnd_valid;

  // FINAL reuses the step counter: the round carry on entry leaves step at 0.
  mskaes_sched_cnt #(
    .SB_LAT (SB_LAT),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (!(in_round || in_final)),
    .en_i        (in_round || in_final),
    .stall_i     (stall),
    .rnd_o       (rnd),
    .step_o      (step),
    .step_wrap_o (step_wrap)
  );

  // State sequencing and key-size latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      key256_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.valid_in) begin
            key256_q <= bus.key256;
            state_q  <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (!stall && step_wrap && last_round) state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          if (step == CNT_W'(FINAL_CYC - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic       o_in_ready, o_busy, o_cipher_valid, o_in_ready_rnd, o_feed_input;
  logic       o_state_enable, o_state_init, o_state_en_mc, o_kh_init, o_kh_enable;
  logic [1:0] o_kh_mode;
  logic       o_rcon_rst, o_rcon_update, o_sbox_valid_in, o_feed_sb_key, o_sb_en;
  logic       o_enable_key_add;

  // Output decode; everything held low while reset is asserted, strobes masked on stall.
  always_comb begin
    o_in_ready       = 1'b0;
    o_busy           = 1'b0;
    o_cipher_valid   = 1'b0;
    o_in_ready_rnd   = 1'b0;
    o_feed_input     = 1'b0;
    o_state_enable   = 1'b0;
    o_state_init     = 1'b0;
    o_state_en_mc    = 1'b0;
    o_kh_init        = 1'b0;
    o_kh_enable      = 1'b0;
    o_kh_mode        = KH_MODE_NONE;
    o_rcon_rst       = 1'b0;
    o_rcon_update    = 1'b0;
    o_sbox_valid_in  = 1'b0;
    o_feed_sb_key    = 1'b0;
    o_sb_en          = 1'b0;
    o_enable_key_add = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          o_in_ready = 1'b1;
          if (bus.valid_in) begin
            o_feed_input = 1'b1;
            o_state_init = 1'b1;
            o_kh_init    = 1'b1;
            o_rcon_rst   = 1'b1;
          end
        end
        ST_ROUND: begin
          o_busy         = 1'b1;
          o_in_ready_rnd = rnd_req;
          o_kh_mode      = kh_mode;
          if (!stall) begin
            o_sbox_valid_in  = sbv_raw;
            o_enable_key_add = col_step;
            o_kh_enable      = col_step;
            o_state_enable   = col_step;
            o_state_en_mc    = col_step && !last_round;
            o_feed_sb_key    = key_step;
            o_sb_en          = 1'b1;
            o_rcon_update    = step_wrap && (kh_mode == KH_MODE_ROT);
          end
        end
        ST_FINAL: begin
          o_busy           = 1'b1;
          o_enable_key_add = 1'b1;
          o_state_enable   = 1'b1;
        end
        ST_DONE: begin
          o_busy         = 1'b1;
          o_cipher_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = o_in_ready;
  assign bus.busy           = o_busy;
  assign bus.cipher_valid   = o_cipher_valid;
  assign bus.in_ready_rnd   = o_in_ready_rnd;
  assign bus.feed_input     = o_feed_input;
  assign bus.state_enable   = o_state_enable;
  assign bus.state_init     = o_state_init;
  assign bus.state_en_MC    = o_state_en_mc;
  assign bus.kh_init        = o_kh_init;
  assign bus.kh_enable      = o_kh_enable;
  assign bus.kh_mode        = o_kh_mode;
  assign bus.rcon_rst       = o_rcon_rst;
  assign bus.rcon_update    = o_rcon_update;
  assign bus.sbox_valid_in  = o_sbox_valid_in;
  assign bus.feed_sb_key    = o_feed_sb_key;
  assign bus.sb_en          = o_sb_en;
  assign bus.enable_key_add = o_enable_key_add;

endmodule

// File: tb/tb_mskaes_32bits_multikey_fsm.sv
// Directed bench for the masked AES control FSM with a latency/count scoreboard.
module tb_mskaes_32bits_multikey_fsm;

  localparam int SB_LAT = 4;
  localparam int RLEN   = 5 + SB_LAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mskaes_32bits_multikey_fsm_if bus();

  mskaes_32bits_multikey_fsm #(
    .SB_LAT (SB_LAT),
    .CNT_W  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int   lat;
    int   rcon;
    int   mc;
    int   nr;
    logic k256;
  } exp_t;
  exp_t sb[$];

  int         rcon_cnt  = 0;
  int         mc_rounds = 0;
  logic       mc_seen   = 1'b0;
  logic [1:0] khq[$];
  int         acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] strobes();
    return {bus.feed_input, bus.state_enable, bus.state_init, bus.state_en_MC,
            bus.kh_init, bus.kh_enable, bus.rcon_rst, bus.rcon_update,
            bus.sbox_valid_in, bus.feed_sb_key, bus.sb_en, bus.enable_key_add};
  endfunction

  function automatic logic [17:0] all_out();
    return {strobes(), bus.in_ready, bus.busy, bus.cipher_valid, bus.in_ready_rnd, bus.kh_mode};
  endfunction

  function automatic logic [1:0] kh_exp(input logic k256, input int r);
    int k;
    k = r + 1;
    if (!k256)          return 2'b01;
    else if (k == 1)    return 2'b00;
    else if (k % 2 == 0) return 2'b01;
    else                return 2'b10;
  endfunction

  // Per-block activity counters, restarted at every accept.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (bus.in_ready && bus.valid_in) begin
        rcon_cnt  = 0;
        mc_rounds = 0;
        mc_seen   = 1'b0;
        khq.delete();
      end
      if (bus.rcon_update) rcon_cnt++;
      if (bus.state_en_MC) mc_seen = 1'b1;
      if (bus.feed_sb_key) begin
        khq.push_back(bus.kh_mode);
        if (mc_seen) mc_rounds++;
        mc_seen = 1'b0;
      end
    end
  end

  task automatic do_accept(input string tag, input logic k, input int stalls);
    exp_t e;
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.key256   = k;
    #1;
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_accept_strobes"},
          {bus.feed_input, bus.state_init, bus.kh_init, bus.rcon_rst, bus.busy}, 5'b11110);
    acc    = cyc;
    e.k256 = k;
    e.nr   = k ? 14 : 10;
    e.lat  = 1 + e.nr * RLEN + 4 + stalls;
    e.rcon = k ? 7 : 10;
    e.mc   = e.nr - 1;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag, input logic hold_valid, input int st_start, input int st_len);
    int   off;
    bit   got;
    exp_t e;
    got = 1'b0;
    off = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      off = int'(cyc) - acc;
      bus.valid_in = hold_valid;
      if (hold_valid) bus.key256 = ~bus.key256;
      bus.rnd_valid = !(off >= st_start && off < st_start + st_len);
      #1;
      if (st_len > 0 && off >= st_start && off < st_start + st_len) begin
        check({tag, "_stall_strobes"}, strobes(), 12'h000);
        check({tag, "_stall_rnd_req"}, bus.in_ready_rnd, 1);
      end
      if (st_len > 0 && off >= st_start + st_len && off < st_start + st_len + 3)
        check({tag, "_resume_col_step"},
              {bus.sbox_valid_in, bus.enable_key_add, bus.kh_enable, bus.state_enable,
               bus.sb_en, bus.feed_sb_key, bus.in_ready_rnd}, 7'b1111101);
      if (st_len > 0 && off == st_start + st_len + 3)
        check({tag, "_resume_key_step"},
              {bus.sbox_valid_in, bus.enable_key_add, bus.kh_enable, bus.state_enable,
               bus.sb_en, bus.feed_sb_key, bus.in_ready_rnd}, 7'b1000111);
      if (hold_valid) check({tag, "_no_reaccept"}, bus.in_ready, 0);
      if (bus.cipher_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, got, 1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, off, e.lat);
      check({tag, "_rcon_pulses"}, rcon_cnt, e.rcon);
      check({tag, "_mc_rounds"}, mc_rounds, e.mc);
      check({tag, "_kh_count"}, khq.size(), e.nr);
      for (int r = 0; r < e.nr && r < khq.size(); r++)
        check({tag, "_kh_mode"}, khq[r], kh_exp(e.k256, r));
    end
  endtask

  task automatic release_out(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      check({tag, "_hold_cipher_valid"}, bus.cipher_valid, 1);
      check({tag, "_hold_in_ready"}, bus.in_ready, 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.valid_in  = 1'b0;
    #1;
    check({tag, "_take_cipher_valid"}, bus.cipher_valid, 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1;
    check({tag, "_idle_after_take"}, {bus.in_ready, bus.busy, bus.cipher_valid}, 3'b100);
  endtask

  initial begin
    bus.valid_in  = 1'b0;
    bus.key256    = 1'b0;
    bus.out_ready = 1'b0;
    bus.rnd_valid = 1'b1;
    rst_n         = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", all_out(), 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_idle", {bus.in_ready, bus.busy, bus.cipher_valid}, 3'b100);

    // AES-128 nominal run
    do_accept("t1", 1'b0, 0);
    wait_done("t1", 1'b0, 0, 0);
    release_out("t1", 0);

    // AES-256 nominal run
    do_accept("t2", 1'b1, 0);
    wait_done("t2", 1'b0, 0, 0);
    release_out("t2", 0);

    // AES-128 with 3-cycle randomness stall at round 2 step 1, then output back-pressure
    do_accept("t3", 1'b0, 3);
    wait_done("t3", 1'b0, 1 + 2 * RLEN + 1, 3);
    release_out("t4", 5);

    // Reset at cycle 40 of an AES-256 run, then a clean AES-128 block
    do_accept("t5", 1'b1, 0);
    for (int i = 0; i < 100 && (int'(cyc) - acc) < 40; i++) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("t5_reset_outputs", all_out(), 18'h0);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    #1;
    check("t5_reset_held", all_out(), 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_idle_after_reset", {bus.in_ready, bus.busy}, 2'b10);
    do_accept("t5b", 1'b0, 0);
    wait_done("t5b", 1'b0, 0, 0);
    release_out("t5b", 0);

    // valid_in held high with key256 toggling during an AES-128 run
    do_accept("t6", 1'b0, 0);
    wait_done("t6", 1'b1, 0, 0);
    release_out("t6", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
